// File: rtl/instr_issue_sequencer.sv
// Instruction issue front end: loadable instruction memory plus a sequential PC that
// feeds the multi-cycle core one word per slot. Define STEP_EN for single-step (PAUSE) mode.
module instr_issue_sequencer #(
    parameter int unsigned IMEM_DEPTH  = 128,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter logic [31:0] HALT_WORD   = 32'hFFFFFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       instrword,
    output logic              newinstr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [15:0]       instr_count
`ifdef STEP_EN
    ,
    input  logic              step
`endif
);

    localparam int unsigned IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_DONE
`ifdef STEP_EN
        ,
        S_PAUSE
`endif
    } state_t;

    state_t            state_q, state_n;
    logic [31:0]       imem [IMEM_DEPTH];
    logic [31:0]       word_n;
    logic [ADDR_W-1:0] pc_n;
    logic [15:0]       cnt_n;
    logic [HC_W-1:0]   hold_q, hold_n;
    logic              mem_we;
    logic              launch;
    logic [ADDR_W:0]   tgt_addr;
    logic [31:0]       tgt_word;
    logic              tgt_stop;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            imem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Target address is one bit wider than pc so pc+1 past the last slot is caught.
    always_comb begin
        tgt_addr = '0;
        if (state_q != S_IDLE && state_q != S_DONE) begin
            tgt_addr = {1'b0, pc} + 1'b1;
        end
        tgt_word = imem[tgt_addr[IDX_W-1:0]];
        tgt_stop = (tgt_addr >= DEPTH_X) || (tgt_word == HALT_WORD);
    end

    always_comb begin
        state_n = state_q;
        word_n  = instrword;
        pc_n    = pc;
        cnt_n   = instr_count;
        hold_n  = hold_q;
        mem_we  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_we) begin
                    mem_we = ({1'b0, load_addr} < DEPTH_X);
                end else if (start) begin
                    cnt_n  = '0;
                    launch = 1'b1;
                end
            end
            S_ISSUE: begin
                state_n = S_HOLD;
                hold_n  = HOLD_LAST;
            end
            S_HOLD: begin
                if (hold_q != '0) begin
                    hold_n = hold_q - 1'b1;
                end else begin
`ifdef STEP_EN
                    state_n = S_PAUSE;
`else
                    launch  = 1'b1;
`endif
                end
            end
`ifdef STEP_EN
            S_PAUSE: begin
                launch = step;
            end
`endif
            default: state_n = S_IDLE;
        endcase
        if (launch) begin
            if (tgt_stop) begin
                state_n = S_DONE;
            end else begin
                state_n = S_ISSUE;
                word_n  = tgt_word;
                pc_n    = tgt_addr[ADDR_W-1:0];
                if (cnt_n != '1) begin
                    cnt_n = cnt_n + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            instrword   <= '0;
            pc          <= '0;
            instr_count <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_n;
            instrword   <= word_n;
            pc          <= pc_n;
            instr_count <= cnt_n;
            hold_q      <= hold_n;
        end
    end

    always_comb begin
        newinstr = (state_q == S_ISSUE);
        done     = (state_q == S_DONE);
        busy     = (state_q == S_ISSUE) || (state_q == S_HOLD);
`ifdef STEP_EN
        busy     = busy || (state_q == S_PAUSE);
`endif
    end

endmodule

// File: doc/instr_issue_sequencer.md
Name: instr_issue_sequencer

Overview:
- Instruction-side front end for the multi-cycle MIPS datapath core.
- Holds a small loadable instruction memory and a PC. Drives the core's `instrword`/`newinstr` inputs, one instruction per issue slot, spaced so the core's control FSM completes each instruction.
- Runs from address 0 after `start`. Stops on a HALT word or at the end of memory.
- No branches. Sequential PC only.

Parameters:
- IMEM_DEPTH, 128, number of 32-bit instruction words.
- ADDR_W, 7, PC/load address width. Requires 2**ADDR_W >= IMEM_DEPTH.
- HOLD_CYCLES, 3, cycles `instrword` is held after the `newinstr` pulse before the next issue. Minimum 1.
- HALT_WORD, 32'hFFFFFFFF, word that terminates the run. It is never issued.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- start, input, 1, begin a run from PC 0.
- load_we, input, 1, instruction memory write enable.
- load_addr, input, ADDR_W, memory write address.
- load_data, input, 32, memory write data.
- instrword, output, 32, instruction to the core. Registered.
- newinstr, output, 1, one-cycle pulse marking a new instrword.
- pc, output, ADDR_W, address of the instruction currently on instrword.
- busy, output, 1, high in ISSUE and HOLD (and PAUSE).
- done, output, 1, high in DONE.
- instr_count, output, 16, instructions issued this run. Saturates at 16'hFFFF.
- step, input, 1, present only with STEP_EN.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, instrword=0, newinstr=0, pc=0, busy=0, done=0, instr_count=0, hold counter=0.
  - Memory contents are retained; they are not cleared.
  - Reset mid-run aborts at that edge, with no further pulses.
- Memory:
  - Written on a clock edge when load_we=1 and state is IDLE or DONE.
  - Writes are ignored in any other state.
  - Writes to addresses >= IMEM_DEPTH are ignored.
  - Reads are combinational from the array.
- States: IDLE, ISSUE, HOLD, DONE (plus PAUSE with STEP_EN).
- IDLE/DONE:
  - start=1 and load_we=0 → evaluate target address 0 (the target check below).
  - start=1 with load_we=1 in the same cycle → the load is performed and start is ignored.
  - start is ignored in every other state.
- Target check for address a:
  - If a >= IMEM_DEPTH or imem[a]==HALT_WORD → DONE.
  - Otherwise → ISSUE, with instrword<=imem[a], pc<=a.
- Entering DONE: instrword and pc hold their last values; newinstr=0.
- ISSUE: exactly one cycle with newinstr=1.
  - instr_count increments on entry, saturating.
  - Next state is HOLD, with counter<=HOLD_CYCLES-1.
- HOLD: newinstr=0; instrword and pc stable.
  - counter≠0 → decrement.
  - counter==0 → target check for pc+1.
- Latency and spacing:
  - start sampled at edge t gives newinstr high in cycle t+1.
  - Consecutive newinstr pulses are exactly 1+HOLD_CYCLES cycles apart.
  - DONE is entered HOLD_CYCLES+1 cycles after the last pulse.
- Starting from DONE: done drops and instr_count clears on the start edge (new run).
- The sequencer does not examine opcodes. HALT_WORD is the only special value.

Optional Feature:
- STEP_EN:
  - Defined: adds the `step` input and a PAUSE state. HOLD with counter==0 goes to PAUSE instead of the target check.
  - In PAUSE, busy stays 1 and instrword is held. A step=1 edge performs the target check for pc+1. Reset and HALT rules are unchanged.
  - Undefined: no step port, no PAUSE; free-running as above.

Test Plan:
- Load [0]=0x00221820, [1]=0x8C040004, [2]=0xAC050008, [3]=0xFFFFFFFF. Start at edge t → newinstr at t+1, t+5, t+9 with those words and pc=0,1,2. done=1 at t+13, instr_count=3, no fourth pulse.
- Load [0]=0xFFFFFFFF, then start → DONE the next cycle, newinstr never asserted, instr_count=0, instrword=0.
- Reset low during the HOLD after the second issue → next cycle all outputs 0, state IDLE. Restart reissues 0x00221820 first, showing memory was retained.
- Mid-run, load_we=1 to [2]=0 and start=1 → both ignored; issued word 2 is 0xAC050008.
- IMEM_DEPTH=8, no HALT, words 1..8 → 8 pulses, pc ends at 7, done=1, instr_count=8.
- STEP_EN: same program as the first test, step pulsed 10 cycles after each PAUSE entry → pulse spacing 1+3+10+1 cycles; without step, busy stays 1 indefinitely after the first instruction.
